// File: rtl/avalon_st_rr_arbiter_16_if.sv
// Ready/valid bundle between NUM_CH word sources, the arbiter and one downstream sink.
// The out_channel signal exists only when ARB_CHANNEL_OUT_EN is defined.
`timescale 1ns/1ps

interface avalon_st_rr_arbiter_16_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 16
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]        in_ready;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic                     out_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
`ifdef ARB_CHANNEL_OUT_EN
    logic [IDX_W-1:0]         out_channel;

    modport slave  (output in_ready, input in_valid, input in_data,
                    input out_ready, output out_valid, output out_data, output out_channel);
    modport master (input in_ready, output in_valid, output in_data,
                    output out_ready, input out_valid, input out_data, input out_channel);
`else
    modport slave  (output in_ready, input in_valid, input in_data,
                    input out_ready, output out_valid, output out_data);
    modport master (input in_ready, output in_valid, output in_data,
                    output out_ready, input out_valid, input out_data);
`endif
endinterface

// File: rtl/avalon_st_rr_arbiter_16.sv
// Round-robin ready/valid scheduler sharing one word sink between NUM_CH sources, with bounded bursts.
// Optional macro ARB_CHANNEL_OUT_EN adds out_channel (granted index) to the interface.
`timescale 1ns/1ps

module avalon_st_rr_arbiter_16 #(
    parameter int NUM_CH    = 2,
    parameter int BURST_LEN = 4,
    parameter int DATA_W    = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    avalon_st_rr_arbiter_16_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(BURST_LEN) + 1;
    localparam logic [IDX_W:0]   NUM_CH_W  = (IDX_W+1)'(NUM_CH);
    localparam logic [IDX_W-1:0] LAST_CH   = IDX_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic {IDLE, GRANTED} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] rrPtr_q;
    logic [CNT_W-1:0] beatCnt_q;

    logic [IDX_W-1:0] grant_d;
    logic [IDX_W-1:0] rrPtr_d;
    logic [IDX_W:0]   idx;
    logic             anyValid;
    logic             grantValid;
    logic             beat;
    logic             lastBeat;

    // Scan from the farthest candidate back to rrPtr so the nearest requester wins.
    always_comb begin
        grant_d  = rrPtr_q;
        anyValid = 1'b0;
        idx      = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = {1'b0, rrPtr_q} + (IDX_W+1)'(k);
            if (idx >= NUM_CH_W) begin
                idx = idx - NUM_CH_W;
            end
            if (bus.in_valid[idx[IDX_W-1:0]]) begin
                grant_d  = idx[IDX_W-1:0];
                anyValid = 1'b1;
            end
        end
    end

    assign rrPtr_d    = (grant_q == LAST_CH) ? '0 : grant_q + IDX_W'(1);
    assign grantValid = bus.in_valid[grant_q];
    assign beat       = (state_q == GRANTED) && grantValid && bus.out_ready;
    assign lastBeat   = (beatCnt_q == LAST_BEAT);

    // A stall (valid without out_ready) keeps both grant and beat count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rrPtr_q   <= '0;
            beatCnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (anyValid) begin
                        state_q   <= GRANTED;
                        grant_q   <= grant_d;
                        beatCnt_q <= '0;
                    end
                end
                GRANTED: begin
                    if ((beat && lastBeat) || !grantValid) begin
                        state_q   <= IDLE;
                        rrPtr_q   <= rrPtr_d;
                        beatCnt_q <= '0;
                    end else if (beat) begin
                        beatCnt_q <= beatCnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = '0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
`ifdef ARB_CHANNEL_OUT_EN
        bus.out_channel = '0;
`endif
        if (state_q == GRANTED) begin
            bus.in_ready[grant_q] = bus.out_ready;
            bus.out_valid         = grantValid;
            bus.out_data          = bus.in_data[int'(grant_q)*DATA_W +: DATA_W];
`ifdef ARB_CHANNEL_OUT_EN
            bus.out_channel       = grant_q;
`endif
        end
    end
endmodule

// File: tb/tb_avalon_st_rr_arbiter_16.sv
// Scoreboard bench: a 2-channel/burst-4 arbiter and a 3-channel/burst-1 arbiter share clock and reset.
// Source queues feed the arbiters; expected words with their arrival cycle are queued up front.
`timescale 1ns/1ps

module tb_avalon_st_rr_arbiter_16;
    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    avalon_st_rr_arbiter_16_if #(.NUM_CH(2), .DATA_W(16)) busA();
    avalon_st_rr_arbiter_16_if #(.NUM_CH(3), .DATA_W(16)) busB();

    avalon_st_rr_arbiter_16 #(.NUM_CH(2), .BURST_LEN(4), .DATA_W(16)) dutA (
        .clock (clock),
        .reset (reset),
        .bus   (busA)
    );

    avalon_st_rr_arbiter_16 #(.NUM_CH(3), .BURST_LEN(1), .DATA_W(16)) dutB (
        .clock (clock),
        .reset (reset),
        .bus   (busB)
    );

    typedef struct {
        logic [15:0] data;
        int          off;
        int          ch;
    } expT;

    expT         expQ[$];
    logic [15:0] src0[$];
    logic [15:0] src1[$];
    logic [15:0] src2[$];

    int total       = 0;
    int bad         = 0;
    int cyc         = 0;
    int testStart   = 0;
    int gapCh       = -1;
    int gapOff      = -1;
    bit useB        = 1'b0;
    bit toggleReady = 1'b0;

    function automatic int srcSize(input int ch);
        case (ch)
            0:       return src0.size();
            1:       return src1.size();
            default: return src2.size();
        endcase
    endfunction

    function automatic logic [15:0] srcFront(input int ch);
        case (ch)
            0:       return src0[0];
            1:       return src1[0];
            default: return src2[0];
        endcase
    endfunction

    task automatic srcPop(input int ch);
        case (ch)
            0:       void'(src0.pop_front());
            1:       void'(src1.pop_front());
            default: void'(src2.pop_front());
        endcase
    endtask

    task automatic srcPush(input int ch, input logic [15:0] d);
        case (ch)
            0:       src0.push_back(d);
            1:       src1.push_back(d);
            default: src2.push_back(d);
        endcase
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic expectWord(input logic [15:0] d, input int off, input int ch);
        expT e;
        e.data = d;
        e.off  = off;
        e.ch   = ch;
        expQ.push_back(e);
    endtask

    // Drive sources from their queues, with an optional one-cycle gap on one channel.
    task automatic applyStimulus(input int off);
        logic [2:0]  v;
        logic [47:0] d;
        v = '0;
        d = '0;
        for (int ch = 0; ch < (useB ? 3 : 2); ch++) begin
            if (srcSize(ch) > 0 && !(ch == gapCh && off == gapOff)) begin
                v[ch]          = 1'b1;
                d[ch*16 +: 16] = srcFront(ch);
            end
        end
        if (useB) begin
            busB.in_valid = v;
            busB.in_data  = d;
            busA.in_valid = '0;
            busA.in_data  = '0;
        end else begin
            busA.in_valid = v[1:0];
            busA.in_data  = d[31:0];
            busB.in_valid = '0;
            busB.in_data  = '0;
        end
        busA.out_ready = toggleReady ? ((off % 2) == 1) : 1'b1;
        busB.out_ready = toggleReady ? ((off % 2) == 1) : 1'b1;
    endtask

    // Inputs are stable here, so what is seen is what the next rising edge will take.
    task automatic sampleOutputs(input int off);
        logic [2:0]  v;
        logic [2:0]  r;
        logic        ov;
        logic        ordy;
        logic [15:0] od;
        int          oc;
        expT         e;
        oc = 0;
        if (useB) begin
            v    = busB.in_valid;
            r    = busB.in_ready;
            ov   = busB.out_valid;
            ordy = busB.out_ready;
            od   = busB.out_data;
`ifdef ARB_CHANNEL_OUT_EN
            oc   = int'(busB.out_channel);
`endif
        end else begin
            v    = {1'b0, busA.in_valid};
            r    = {1'b0, busA.in_ready};
            ov   = busA.out_valid;
            ordy = busA.out_ready;
            od   = busA.out_data;
`ifdef ARB_CHANNEL_OUT_EN
            oc   = int'(busA.out_channel);
`endif
        end
        checkOutput("rdy_onehot", 32'($countones(r) <= 1), 32'(1));
        for (int ch = 0; ch < 3; ch++) begin
            if (v[ch] && r[ch]) begin
                srcPop(ch);
            end
        end
        if (ov && ordy) begin
            checkOutput("sb_pending", 32'(expQ.size() > 0), 32'(1));
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("word_data", 32'(od), 32'(e.data));
                checkOutput("word_cycle", 32'(off), 32'(e.off));
`ifdef ARB_CHANNEL_OUT_EN
                checkOutput("word_chan", 32'(oc), 32'(e.ch));
`endif
            end
        end else if (ov && expQ.size() > 0) begin
            checkOutput("stall_data", 32'(od), 32'(expQ[0].data));
        end
    endtask

    task automatic stepCycle();
        int off;
        @(negedge clock);
        off = cyc - testStart;
        applyStimulus(off);
        #1;
        sampleOutputs(off);
        cyc++;
    endtask

    task automatic startTest();
        testStart = cyc;
    endtask

    task automatic zeroInputs();
        busA.in_valid  = '0;
        busA.in_data   = '0;
        busA.out_ready = 1'b0;
        busB.in_valid  = '0;
        busB.in_data   = '0;
        busB.out_ready = 1'b0;
    endtask

    task automatic resetDut();
        @(negedge clock);
        zeroInputs();
        reset = 1'b1;
        #1;
        checkOutput("rst_a_valid", 32'(busA.out_valid), 32'(0));
        checkOutput("rst_a_ready", 32'(busA.in_ready), 32'(0));
        checkOutput("rst_a_data", 32'(busA.out_data), 32'(0));
        checkOutput("rst_b_valid", 32'(busB.out_valid), 32'(0));
        checkOutput("rst_b_ready", 32'(busB.in_ready), 32'(0));
`ifdef ARB_CHANNEL_OUT_EN
        checkOutput("rst_a_chan", 32'(busA.out_channel), 32'(0));
`endif
        repeat (2) @(negedge clock);
        reset       = 1'b0;
        gapCh       = -1;
        gapOff      = -1;
        toggleReady = 1'b0;
    endtask

    initial begin
        zeroInputs();

        // Single channel: two bursts of four separated by one bubble.
        resetDut();
        useB = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            srcPush(0, 16'(n));
            expectWord(16'(n), (n <= 4) ? n : n + 1, 0);
        end
        startTest();
        for (int k = 0; k < 12; k++) begin
            stepCycle();
            checkOutput("t1_rdy1", 32'(busA.in_ready[1]), 32'(0));
        end
        checkOutput("t1_sb_empty", 32'(expQ.size()), 32'(0));

        // Both channels always valid: bursts alternate 0,1,0,1.
        resetDut();
        for (int n = 0; n < 8; n++) begin
            srcPush(0, 16'hA000 + 16'(n));
            srcPush(1, 16'hB000 + 16'(n));
        end
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 4; j++) begin
                expectWord(((b % 2) == 1 ? 16'hB000 : 16'hA000) + 16'((b / 2) * 4 + j),
                           1 + 5 * b + j, b % 2);
            end
        end
        startTest();
        for (int k = 0; k < 22; k++) stepCycle();
        checkOutput("t2_sb_empty", 32'(expQ.size()), 32'(0));

        // Backpressure on ch1: ready toggles, stalls neither count nor change data.
        resetDut();
        toggleReady = 1'b1;
        for (int n = 0; n < 6; n++) begin
            srcPush(1, 16'hC000 + 16'(n));
            expectWord(16'hC000 + 16'(n), 1 + 2 * n, 1);
        end
        startTest();
        for (int k = 0; k < 13; k++) begin
            stepCycle();
            if ((k >= 1 && k <= 7) || (k >= 9 && k <= 11)) begin
                checkOutput("t3_rdy_mirror", 32'(busA.in_ready[1]), 32'(busA.out_ready));
            end
        end
        checkOutput("t3_sb_empty", 32'(expQ.size()), 32'(0));

        // Idle gap on ch0 after two words releases the grant; ch1 then wins the tie.
        resetDut();
        gapCh  = 0;
        gapOff = 3;
        for (int n = 0; n < 3; n++) srcPush(0, 16'hD000 + 16'(n));
        for (int n = 0; n < 4; n++) srcPush(1, 16'hE000 + 16'(n));
        expectWord(16'hD000, 1, 0);
        expectWord(16'hD001, 2, 0);
        for (int n = 0; n < 4; n++) expectWord(16'hE000 + 16'(n), 5 + n, 1);
        expectWord(16'hD002, 10, 0);
        startTest();
        for (int k = 0; k < 13; k++) stepCycle();
        checkOutput("t4_sb_empty", 32'(expQ.size()), 32'(0));

        // Asynchronous reset after two beats of ch1; the third word stays at the source.
        resetDut();
        for (int n = 0; n < 4; n++) srcPush(1, 16'hF000 + 16'(n));
        expectWord(16'hF000, 1, 1);
        expectWord(16'hF001, 2, 1);
        startTest();
        for (int k = 0; k < 3; k++) stepCycle();
        @(negedge clock);
        applyStimulus(3);
        #1;
        checkOutput("t5_pre_valid", 32'(busA.out_valid), 32'(1));
        reset = 1'b1;
        #1;
        checkOutput("t5_async_valid", 32'(busA.out_valid), 32'(0));
        checkOutput("t5_async_ready", 32'(busA.in_ready), 32'(0));
        checkOutput("t5_async_data", 32'(busA.out_data), 32'(0));
        @(negedge clock);
        zeroInputs();
        reset = 1'b0;
        checkOutput("t5_sb_before", 32'(expQ.size()), 32'(0));
        checkOutput("t5_src_kept", 32'(src1.size()), 32'(2));
        srcPush(0, 16'h1110);
        srcPush(0, 16'h1111);
        expectWord(16'h1110, 1, 0);
        expectWord(16'h1111, 2, 0);
        expectWord(16'hF002, 5, 1);
        expectWord(16'hF003, 6, 1);
        startTest();
        for (int k = 0; k < 9; k++) stepCycle();
        checkOutput("t5_sb_empty", 32'(expQ.size()), 32'(0));

        // Three channels, burst of one: strict word-level rotation 0,1,2,0,...
        resetDut();
        useB = 1'b1;
        for (int n = 0; n < 3; n++) begin
            for (int ch = 0; ch < 3; ch++) srcPush(ch, 16'h7000 + 16'(ch * 256 + n));
        end
        for (int k = 0; k < 9; k++) begin
            expectWord(16'h7000 + 16'((k % 3) * 256 + k / 3), 1 + 2 * k, k % 3);
        end
        startTest();
        for (int k = 0; k < 20; k++) stepCycle();
        checkOutput("t6_sb_empty", 32'(expQ.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/avalon_st_rr_arbiter_16.md
Name: avalon_st_rr_arbiter_16

Overview:
- Shares one downstream 16-bit Avalon-ST sink (the Hamming encoder input) between NUM_CH upstream 16-bit word sources, e.g. several byte-to-word packing stages.
- Round-robin grant, held for a bounded burst of words, then rotated.
- Pure ready/valid scheduler: no data buffering, one arbitration cycle per grant.

Parameters:
- NUM_CH, 2, number of requesting channels; legal range 2..8.
- BURST_LEN, 4, maximum words accepted per grant before forced rotation; must be at least 1.
- DATA_W, 16, word width of every channel and of the output.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_ready  output  NUM_CH  per-channel ready; bit i belongs to channel i.
- in_valid  input  NUM_CH  per-channel valid.
- in_data  input  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- out_ready  input  1  downstream ready.
- out_valid  output  1  downstream valid.
- out_data  output  DATA_W  downstream word.
- out_channel  output  clog2(NUM_CH)  index of the granted channel; present only with ARB_CHANNEL_OUT_EN.

Behaviour:
- Reset (asynchronous, any cycle, including mid-burst):
  - state=IDLE, grant=0, rr_ptr=0, beat_cnt=0.
  - in_ready all 0, out_valid=0, out_data=0.
  - A word presented but not handshaken at reset is not consumed; the source keeps it.
- States: IDLE, GRANTED.
- IDLE:
  - All in_ready=0, out_valid=0, out_data=0.
  - If any in_valid is set: grant <= first set channel searching rr_ptr, rr_ptr+1, ... modulo NUM_CH. Next state GRANTED, beat_cnt <= 0.
  - If no in_valid is set: stay in IDLE.
  - Arbitration latency is exactly 1 cycle from valid to grant.
- GRANTED with channel g:
  - Combinational pass-through: out_valid=in_valid[g], out_data=in_data[g], in_ready[g]=out_ready. All other in_ready bits are 0.
  - out_valid never depends on out_ready.
  - A beat is a cycle with in_valid[g] and out_ready both high; each beat increments beat_cnt.
- Release from GRANTED, checked in priority order:
  - (a) A beat occurs with beat_cnt==BURST_LEN-1.
  - (b) in_valid[g]==0, i.e. the source has an idle gap. Release happens in that same cycle, with no beat.
  - On release: next state IDLE, rr_ptr <= (g+1) mod NUM_CH, beat_cnt <= 0.
  - out_ready low with in_valid[g] high is a stall, not a release: hold the grant and beat_cnt unchanged.
- Each grant change therefore costs one bubble cycle in IDLE.
- BURST_LEN=1: release after every beat, giving strict word-level round-robin.
- Fairness: a channel continuously valid waits at most (NUM_CH-1)*(BURST_LEN+1) cycles of other traffic, excluding downstream stalls.
- Simultaneous requests in IDLE: rr_ptr breaks the tie. After reset, channel 0 wins.
- Wrap-around: rr_ptr at NUM_CH-1 advances to 0. beat_cnt width is clog2(BURST_LEN)+1 and it never overflows.
- Ordering: words from one channel reach the output in source order. No word is duplicated or dropped.

Optional Feature:
- Macro: ARB_CHANNEL_OUT_EN.
- Defined:
  - out_channel port exists and equals grant while in GRANTED; it is 0 in IDLE and at reset.
  - It is valid in every cycle where out_valid=1.
- Undefined:
  - Port absent; arbitration and timing are identical.

Test Plan:
- Single channel, NUM_CH=2, BURST_LEN=4: ch0 streams 0x0001..0x0008, out_ready=1 -> output shows 0x0001..0x0004, one bubble, then 0x0005..0x0008. in_ready[1]=0 throughout.
- Both channels continuously valid (ch0 0xA000+n, ch1 0xB000+n) -> output 0xA000..0xA003, bubble, 0xB000..0xB003, bubble, 0xA004...; out_channel alternates 0,1 when ARB_CHANNEL_OUT_EN is defined.
- Backpressure: out_ready toggles 1,0,1,0 during a ch1 burst -> in_ready[1] mirrors out_ready. Exactly 4 beats are accepted before release, beat_cnt holds on stalled cycles, and data is unchanged while stalled.
- Idle gap: ch0 valid for 2 words then drops for 1 cycle, ch1 valid -> release after word 2; ch1 is granted next and rr_ptr=1 afterwards.
- Reset asserted mid-burst after 2 beats on ch1 -> out_valid and in_ready drop immediately (asynchronous). After deassert with both channels valid, ch0 is granted first (rr_ptr=0).
- BURST_LEN=1, NUM_CH=3, all valid -> channel order 0,1,2,0,... with one word each and a bubble between words.
